// File: rtl/bit_pop_gen_pkg.sv
// Shared types and helpers for the bit population generator: FSM state
// encoding and the thermometer-mask builder.
package bit_pop_gen_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

    // Widest frame the mask builder supports; callers truncate to their WIDTH.
    localparam int unsigned THERM_MAX_W = 256;

    // Mask with bits [n-1:0] set. A shift of n >= THERM_MAX_W yields all ones.
    function automatic logic [THERM_MAX_W-1:0] thermometer(input int unsigned n);
        return ~({THERM_MAX_W{1'b1}} << n);
    endfunction

endpackage

// File: rtl/bit_serializer_lsb.sv
// Loads a WIDTH-bit word and shifts it out LSB first, one bit per cycle,
// with valid, last and busy qualifiers.
module bit_serializer_lsb
    import bit_pop_gen_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             arst_n_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] word_i,
    output logic             data_o,
    output logic             val_o,
    output logic             last_o,
    output logic             busy_o
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic             sending;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            shreg_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            shreg_q <= shreg_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        shreg_d = shreg_q;
        case (state_q)
            IDLE: begin
                if (load_i) begin
                    shreg_d = word_i;
                    idx_d   = '0;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (idx_q == LAST_IDX) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    shreg_d = '0;
                end else begin
                    idx_d   = idx_q + IDX_W'(1);
                    shreg_d = shreg_q >> 1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Qualifiers come straight from flops; data and last are forced low when idle.
    assign sending = (state_q == SEND);
    assign val_o   = sending;
    assign busy_o  = sending;
    assign data_o  = sending & shreg_q[0];
    assign last_o  = sending & (idx_q == LAST_IDX);

endmodule

// File: rtl/bit_population_generator.sv
// Turns a population count N into a WIDTH-bit thermometer frame with exactly
// min(N, WIDTH) ones, emitted as a registered word and serially LSB first.
module bit_population_generator
    import bit_pop_gen_pkg::*;
#(
    parameter  int WIDTH = 16,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             arst_n_i,
    input  logic [CNT_W-1:0] data_i,
    input  logic             data_val_i,
    output logic [WIDTH-1:0] word_o,
    output logic             word_val_o,
    output logic             ser_data_o,
    output logic             ser_data_val_o,
    output logic             ser_last_o,
    output logic             busy_o
);

    logic             busy;
    logic             accept;
    logic [CNT_W-1:0] n_eff;
    logic [WIDTH-1:0] therm;
    logic [WIDTH-1:0] word_q, word_d;
    logic             word_val_q, word_val_d;

    // Requests arriving mid-frame are dropped, never queued.
    assign accept = data_val_i & ~busy;

    always_comb begin
        n_eff = (data_i > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : data_i;
        therm = WIDTH'(thermometer(32'(n_eff)));
    end

    always_comb begin
        word_d     = accept ? therm : word_q;
        word_val_d = accept;
    end

    always_ff @(posedge clk or negedge arst_n_i) begin
        if (!arst_n_i) begin
            word_q     <= '0;
            word_val_q <= 1'b0;
        end else begin
            word_q     <= word_d;
            word_val_q <= word_val_d;
        end
    end

    bit_serializer_lsb #(
        .WIDTH (WIDTH)
    ) u_serializer (
        .clk      (clk),
        .arst_n_i (arst_n_i),
        .load_i   (accept),
        .word_i   (therm),
        .data_o   (ser_data_o),
        .val_o    (ser_data_val_o),
        .last_o   (ser_last_o),
        .busy_o   (busy)
    );

    assign word_o     = word_q;
    assign word_val_o = word_val_q;
    assign busy_o     = busy;

endmodule

// File: tb/tb_bit_population_generator.sv
// Self-checking bench: a WIDTH=16 instance checked sample-by-sample against a
// frame-level model, plus a WIDTH=8 instance in a random loop-back run.
module tb_bit_population_generator;

    logic        clk;
    logic        arst_n;

    logic [4:0]  data16;
    logic        dval16;
    logic [15:0] word16;
    logic        wval16, sdata16, val16, last16, busy16;

    logic [3:0]  data8;
    logic        dval8;
    logic [7:0]  word8;
    logic        wval8, sdata8, val8, last8, busy8;

    int errors = 0;
    int checks = 0;

    // Sample vector layout: {busy, val, data, last, word_val}
    logic [4:0]  cap_sig[64];
    logic [15:0] cap_word[64];
    logic [4:0]  exp_sig[64];
    logic [15:0] exp_word[64];
    logic [15:0] model_word;

    bit_population_generator #(.WIDTH(16)) dut16 (
        .clk            (clk),
        .arst_n_i       (arst_n),
        .data_i         (data16),
        .data_val_i     (dval16),
        .word_o         (word16),
        .word_val_o     (wval16),
        .ser_data_o     (sdata16),
        .ser_data_val_o (val16),
        .ser_last_o     (last16),
        .busy_o         (busy16)
    );

    bit_population_generator #(.WIDTH(8)) dut8 (
        .clk            (clk),
        .arst_n_i       (arst_n),
        .data_i         (data8),
        .data_val_i     (dval8),
        .word_o         (word8),
        .word_val_o     (wval8),
        .ser_data_o     (sdata8),
        .ser_data_val_o (val8),
        .ser_last_o     (last8),
        .busy_o         (busy8)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [4:0] sig16();
        return {busy16, val16, sdata16, last16, wval16};
    endfunction

    // Records n post-edge samples; afterwards drives the request for the next edge.
    task automatic capture(input int n, input logic hold, input logic [4:0] later_data,
                           input int pulse_at, input logic [4:0] pulse_data);
        for (int i = 0; i < n; i++) begin
            tick();
            cap_sig[i]  = sig16();
            cap_word[i] = word16;
            if (hold) begin
                dval16 = 1'b1;
                data16 = later_data;
            end else if (i == pulse_at) begin
                dval16 = 1'b1;
                data16 = pulse_data;
            end else begin
                dval16 = 1'b0;
            end
        end
    endtask

    // Model: every sample idle, parallel word holding its last value.
    task automatic model_idle(input int n);
        for (int i = 0; i < n; i++) begin
            exp_sig[i]  = 5'b0;
            exp_word[i] = model_word;
        end
    endtask

    // Model: a frame for request n_req whose bit 0 appears at sample 'start'.
    task automatic model_frame(input int start, input int n_req);
        int          neff;
        logic [31:0] w;
        neff = (n_req > 16) ? 16 : n_req;
        w    = (32'd1 << neff) - 32'd1;
        for (int k = 0; k < 16; k++)
            exp_sig[start + k] = {1'b1, 1'b1, (k < neff), (k == 15), (k == 0)};
        for (int i = start; i < 64; i++)
            exp_word[i] = w[15:0];
        model_word = w[15:0];
    endtask

    task automatic test_reset();
        arst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            data16 = 5'd5;
            dval16 = i[0];
            tick();
            checks++;
            if (sig16() !== 5'b0 || word16 !== 16'h0) begin
                errors++;
                $display("FAIL reset_hold cycle %0d: got sig=%b word=%h, expected sig=00000 word=0000",
                         i, sig16(), word16);
            end
        end
        dval16 = 1'b0;
        arst_n = 1'b1;
        model_word = 16'h0;
        tick();
        data16 = 5'd5;
        dval16 = 1'b1;
        capture(18, 1'b0, 5'd0, -1, 5'd0);
        model_idle(18);
        model_frame(0, 5);
        for (int i = 0; i < 18; i++) begin
            checks++;
            if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                errors++;
                $display("FAIL first_frame sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                         i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_saturation();
        int reqs[3] = '{0, 16, 20};
        int exp_ones[3] = '{0, 16, 16};
        for (int r = 0; r < 3; r++) begin
            int ones;
            data16 = 5'(reqs[r]);
            dval16 = 1'b1;
            capture(17, 1'b0, 5'd0, -1, 5'd0);
            model_idle(17);
            model_frame(0, reqs[r]);
            ones = 0;
            for (int i = 0; i < 17; i++) begin
                if (cap_sig[i][3]) ones += int'(cap_sig[i][2]);
                checks++;
                if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                    errors++;
                    $display("FAIL saturation n=%0d sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                             reqs[r], i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
                end
            end
            checks++;
            if (ones !== exp_ones[r]) begin
                errors++;
                $display("FAIL saturation_sum n=%0d: got %0d ones, expected %0d", reqs[r], ones, exp_ones[r]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int gaps;
        data16 = 5'd3;
        dval16 = 1'b1;
        capture(33, 1'b1, 5'd7, -1, 5'd0);
        dval16 = 1'b0;
        model_idle(33);
        model_frame(0, 3);
        model_frame(17, 7);
        gaps = 0;
        for (int i = 0; i < 33; i++) begin
            if (!cap_sig[i][3]) gaps++;
            checks++;
            if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                errors++;
                $display("FAIL back_to_back sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                         i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
            end
        end
        checks++;
        if (gaps !== 1) begin
            errors++;
            $display("FAIL back_to_back_gap: got %0d idle cycles, expected 1", gaps);
        end
        tick();
    endtask

    task automatic test_mid_frame_request();
        data16 = 5'd9;
        dval16 = 1'b1;
        capture(20, 1'b0, 5'd0, 4, 5'd2);
        model_idle(20);
        model_frame(0, 9);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                errors++;
                $display("FAIL mid_frame sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                         i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        data16 = 5'd12;
        dval16 = 1'b1;
        capture(7, 1'b0, 5'd0, -1, 5'd0);
        model_idle(7);
        model_frame(0, 12);
        for (int i = 0; i < 7; i++) begin
            checks++;
            if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                errors++;
                $display("FAIL abort_prefix sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                         i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
            end
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if (sig16() !== 5'b0 || word16 !== 16'h0) begin
            errors++;
            $display("FAIL abort_async: got sig=%b word=%h, expected sig=00000 word=0000", sig16(), word16);
        end
        tick();
        arst_n = 1'b1;
        model_word = 16'h0;
        capture(20, 1'b0, 5'd0, -1, 5'd0);
        model_idle(20);
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                errors++;
                $display("FAIL abort_quiet sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                         i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
            end
        end
    endtask

    task automatic test_random_frames();
        for (int f = 0; f < 30; f++) begin
            int n, gap, pulse_at;
            n        = int'($urandom_range(0, 31));
            gap      = int'($urandom_range(0, 3));
            pulse_at = int'($urandom_range(0, 15));
            for (int g = 0; g < gap; g++) tick();
            data16 = 5'(n);
            dval16 = 1'b1;
            capture(17, 1'b0, 5'd0, pulse_at, 5'($urandom_range(0, 31)));
            model_idle(17);
            model_frame(0, n);
            for (int i = 0; i < 17; i++) begin
                checks++;
                if (cap_sig[i] !== exp_sig[i] || cap_word[i] !== exp_word[i]) begin
                    errors++;
                    $display("FAIL random n=%0d sample %0d: got sig=%b word=%h, expected sig=%b word=%h",
                             n, i, cap_sig[i], cap_word[i], exp_sig[i], exp_word[i]);
                end
            end
        end
    endtask

    task automatic test_loopback8();
        for (int f = 0; f < 200; f++) begin
            int          n, neff, ones, count, last_pos;
            logic [15:0] t;
            logic [7:0]  w8;
            n    = int'($urandom_range(0, 15));
            neff = (n > 8) ? 8 : n;
            t    = (16'd1 << neff) - 16'd1;
            w8   = t[7:0];
            data8 = 4'(n);
            dval8 = 1'b1;
            ones = 0;
            count = 0;
            last_pos = -1;
            for (int c = 0; c < 11; c++) begin
                tick();
                dval8 = 1'b0;
                if (val8) begin
                    if (last8) last_pos = count;
                    ones += int'(sdata8);
                    count++;
                end
            end
            checks++;
            if (ones !== neff) begin
                errors++;
                $display("FAIL loopback_pop n=%0d: got %0d, expected %0d", n, ones, neff);
            end
            checks++;
            if (count !== 8 || last_pos !== 7) begin
                errors++;
                $display("FAIL loopback_len n=%0d: got %0d bits last at %0d, expected 8 bits last at 7",
                         n, count, last_pos);
            end
            checks++;
            if (word8 !== w8) begin
                errors++;
                $display("FAIL loopback_word n=%0d: got %h, expected %h", n, word8, w8);
            end
        end
    endtask

    initial begin
        arst_n = 1'b0;
        data16 = '0;
        dval16 = 1'b0;
        data8  = '0;
        dval8  = 1'b0;
        model_word = 16'h0;
        test_reset();
        test_saturation();
        test_back_to_back();
        test_mid_frame_request();
        test_async_reset();
        test_random_frames();
        test_loopback8();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
